cnn_conv_engine: RTL and testbench

//  Parametrised hardware convolution engine for the CNN-16 processor; replaces the microcoded

---
 rtl/cnn_pkg.sv | 13 +
 rtl/cnn_mac_sat.sv | 45 ++++
 rtl/cnn_conv_engine.sv | 152 +++++++++++++++
 tb/tb_cnn_conv_engine.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared FSM state encoding, tap count and saturation bound helpers for the convolution engine
package cnn_pkg;
   typedef enum logic [2:0] {S_IDLE, S_LOAD_K, S_FETCH, S_WRITE, S_ERR, S_DONE} state_e;
   function automatic int k_taps(input int k);
      return k * k;
   endfunction
   function automatic logic signed [63:0] sat_hi(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction
   function automatic logic signed [63:0] sat_lo(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction
endpackage

// File: rtl/cnn_mac_sat.sv
// cnn_mac_sat: signed multiply-accumulate, arithmetic right shift, saturation, optional ReLU.
//   clk_i/rst_ni : clock, asynchronous active-low reset
//   clr_i        : zero the accumulator (start of a window)
//   en_i         : accumulate pix_i*ker_i
//   shift_i      : arithmetic right shift applied to the accumulator
//   res_o        : saturated (and, with CNN_RELU_EN defined, rectified) result
module cnn_mac_sat
   import cnn_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 40
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clr_i,
   input  logic              en_i,
   input  logic [DATA_W-1:0] pix_i,
   input  logic [DATA_W-1:0] ker_i,
   input  logic [4:0]        shift_i,
   output logic [DATA_W-1:0] res_o
);
   localparam logic signed [63:0] HI = sat_hi(DATA_W);
   localparam logic signed [63:0] LO = sat_lo(DATA_W);
   logic signed [2*DATA_W-1:0] pix_x, ker_x, prod;
   logic signed [ACC_W-1:0]    acc_q, acc_d, acc_sh;
   logic signed [63:0]         wide;
   logic [DATA_W-1:0]          sat;
   // operands widened first so the product is a full 2*DATA_W signed value
   assign pix_x  = {{DATA_W{pix_i[DATA_W-1]}}, pix_i};
   assign ker_x  = {{DATA_W{ker_i[DATA_W-1]}}, ker_i};
   assign prod   = pix_x * ker_x;
   assign acc_d  = clr_i ? '0 : en_i ? acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod} : acc_q;
   assign acc_sh = acc_q >>> shift_i;
   assign wide   = {{(64-ACC_W){acc_sh[ACC_W-1]}}, acc_sh};
   assign sat    = wide > HI ? HI[DATA_W-1:0] : wide < LO ? LO[DATA_W-1:0] : wide[DATA_W-1:0];
`ifdef CNN_RELU_EN
   assign res_o  = sat[DATA_W-1] ? '0 : sat;
`else
   assign res_o  = sat;
`endif
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) acc_q <= '0;
      else acc_q <= acc_d;
   end
endmodule

// File: rtl/cnn_conv_engine.sv
// cnn_conv_engine: KxK sliding-window convolution over an image in shared single-port memory.
//   clk_i/rst_ni            : clock, asynchronous active-low reset (aborts a job immediately)
//   start_i                 : launch a job, sampled only while idle
//   img/ker/out_base_i      : row-major image, kernel and output base addresses
//   img_w_i/img_h_i         : image dimensions; below K in either is an error job
//   shift_i                 : arithmetic right shift applied to each MAC result
//   mem_rd_req_o/wr_req_o   : memory request, held with addr/wdata until mem_ready_i
//   mem_addr_o/mem_wdata_o  : transaction address / write data
//   mem_rdata_i/mem_ready_i : read data and completion strobe
//   busy_o/done_o/err_o     : job active, one-cycle completion pulse, sticky illegal-dims flag
// Build option: CNN_RELU_EN clamps negative results to zero before write-back.
module cnn_conv_engine
   import cnn_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 12,
   parameter int DIM_W  = 8,
   parameter int K      = 3,
   parameter int ACC_W  = 40
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] img_base_i,
   input  logic [ADDR_W-1:0] ker_base_i,
   input  logic [ADDR_W-1:0] out_base_i,
   input  logic [DIM_W-1:0]  img_w_i,
   input  logic [DIM_W-1:0]  img_h_i,
   input  logic [4:0]        shift_i,
   output logic              mem_rd_req_o,
   output logic              mem_wr_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ready_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);
   localparam int K_TAPS = k_taps(K);
   localparam int TW = K_TAPS > 1 ? $clog2(K_TAPS) : 1;
   localparam int KW = K > 1 ? $clog2(K) : 1;
   localparam int WW = ADDR_W + 2 * DIM_W;
   localparam logic [TW-1:0]    TAP_LAST = TW'(K_TAPS - 1);
   localparam logic [KW-1:0]    K_LAST   = KW'(K - 1);
   localparam logic [DIM_W-1:0] K_DIM    = DIM_W'(K);
   localparam logic [DIM_W-1:0] K_M1     = DIM_W'(K - 1);
   state_e            state_q;
   logic [ADDR_W-1:0] img_base_q, ker_base_q, out_base_q;
   logic [DIM_W-1:0]  img_w_q, ow_q, oh_q, ox_q, oy_q;
   logic [4:0]        shift_q;
   logic [TW-1:0]     tap_q;
   logic [KW-1:0]     kx_q, ky_q;
   logic [DATA_W-1:0] ker_q [K_TAPS];
   logic              busy_q, done_q, err_q;
   logic              bad_dims, last_out, mac_clr, mac_en;
   logic [DATA_W-1:0] mac_res;
   assign bad_dims     = img_w_i < K_DIM || img_h_i < K_DIM;
   assign last_out     = ox_q == ow_q - 1'b1 && oy_q == oh_q - 1'b1;
   assign mem_rd_req_o = state_q == S_LOAD_K || state_q == S_FETCH;
   assign mem_wr_req_o = state_q == S_WRITE;
   // address terms are formed wide and truncated, so every address wraps modulo 2^ADDR_W
   assign mem_addr_o   = state_q == S_LOAD_K ? ker_base_q + ADDR_W'(tap_q)
                       : state_q == S_FETCH  ? img_base_q + ADDR_W'((WW'(oy_q) + WW'(ky_q)) * WW'(img_w_q) + WW'(ox_q) + WW'(kx_q))
                       : state_q == S_WRITE  ? out_base_q + ADDR_W'(WW'(oy_q) * WW'(ow_q) + WW'(ox_q))
                       : '0;
   assign mem_wdata_o  = mem_wr_req_o ? mac_res : '0;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign err_o        = err_q;
   // accumulator is zeroed on every edge that enters FETCH: end of kernel load, or a completed write
   assign mac_clr = mem_ready_i && ((state_q == S_LOAD_K && tap_q == TAP_LAST) || state_q == S_WRITE);
   assign mac_en  = mem_ready_i && state_q == S_FETCH;
   cnn_mac_sat #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (mac_clr),
      .en_i    (mac_en),
      .pix_i   (mem_rdata_i),
      .ker_i   (ker_q[tap_q]),
      .shift_i (shift_q),
      .res_o   (mac_res)
   );
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         img_base_q <= '0;
         ker_base_q <= '0;
         out_base_q <= '0;
         img_w_q    <= '0;
         ow_q       <= '0;
         oh_q       <= '0;
         ox_q       <= '0;
         oy_q       <= '0;
         shift_q    <= '0;
         tap_q      <= '0;
         kx_q       <= '0;
         ky_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         for (int i = 0; i < K_TAPS; i++) ker_q[i] <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: if (start_i) begin
               img_base_q <= img_base_i;
               ker_base_q <= ker_base_i;
               out_base_q <= out_base_i;
               img_w_q    <= img_w_i;
               ow_q       <= img_w_i - K_M1;
               oh_q       <= img_h_i - K_M1;
               shift_q    <= shift_i;
               tap_q      <= '0;
               kx_q       <= '0;
               ky_q       <= '0;
               ox_q       <= '0;
               oy_q       <= '0;
               busy_q     <= 1'b1;
               err_q      <= bad_dims;
               state_q    <= bad_dims ? S_ERR : S_LOAD_K;
            end
            S_LOAD_K: if (mem_ready_i) begin
               ker_q[tap_q] <= mem_rdata_i;
               tap_q        <= tap_q == TAP_LAST ? '0 : tap_q + 1'b1;
               if (tap_q == TAP_LAST) state_q <= S_FETCH;
            end
            S_FETCH: if (mem_ready_i) begin
               tap_q <= tap_q == TAP_LAST ? '0 : tap_q + 1'b1;
               kx_q  <= kx_q == K_LAST ? '0 : kx_q + 1'b1;
               if (kx_q == K_LAST) ky_q <= ky_q == K_LAST ? '0 : ky_q + 1'b1;
               if (tap_q == TAP_LAST) state_q <= S_WRITE;
            end
            S_WRITE: if (mem_ready_i) begin
               ox_q    <= ox_q == ow_q - 1'b1 ? '0 : ox_q + 1'b1;
               if (ox_q == ow_q - 1'b1) oy_q <= oy_q + 1'b1;
               state_q <= last_out ? S_DONE : S_FETCH;
               done_q  <= last_out;
            end
            S_ERR: begin
               state_q <= S_DONE;
               done_q  <= 1'b1;
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cnn_conv_engine.sv
// tb_cnn_conv_engine: directed bench with a memory model and a loop-level reference convolution
module tb_cnn_conv_engine;
   localparam int K = 3;
   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [11:0] img_base = '0, ker_base = '0, out_base = '0;
   logic [7:0]  img_w = '0, img_h = '0;
   logic [4:0]  shift = '0;
   logic        rd, wr, busy, done, err;
   logic        ready = 1'b1;
   logic [11:0] addr;
   logic [15:0] wdata, rdata;
   logic [15:0] mem [4096];
   int          tests = 0, fails = 0;
   int          exp_rd[$], exp_wa[$], exp_wd[$];
   bit          stall_en = 1'b0;
   logic        p_rd = 1'b0, p_wr = 1'b0, p_rdy = 1'b1;
   logic [11:0] p_addr = '0;
   logic [15:0] p_wdata = '0;
   int          dn;

   always #5 clk = ~clk;
   assign rdata = mem[addr];

   cnn_conv_engine #(.DATA_W(16), .ADDR_W(12), .DIM_W(8), .K(K), .ACC_W(40)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .img_base_i   (img_base),
      .ker_base_i   (ker_base),
      .out_base_i   (out_base),
      .img_w_i      (img_w),
      .img_h_i      (img_h),
      .shift_i      (shift),
      .mem_rd_req_o (rd),
      .mem_wr_req_o (wr),
      .mem_addr_o   (addr),
      .mem_wdata_o  (wdata),
      .mem_rdata_i  (rdata),
      .mem_ready_i  (ready),
      .busy_o       (busy),
      .done_o       (done),
      .err_o        (err)
   );

   task automatic chk(input string name, input longint got, input longint want);
      tests++;
      if (got != want) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
      end
   endtask

   // reference: plain nested loops over windows, producing the read address stream and the writes
   task automatic build_expect(input int ib, input int kb, input int ob, input int w, input int h, input int sh);
      longint s;
      int     a;
      exp_rd.delete();
      exp_wa.delete();
      exp_wd.delete();
      if (w < K || h < K) return;
      for (int i = 0; i < K * K; i++) exp_rd.push_back((kb + i) % 4096);
      for (int oy = 0; oy <= h - K; oy++)
         for (int ox = 0; ox <= w - K; ox++) begin
            s = 0;
            for (int ky = 0; ky < K; ky++)
               for (int kx = 0; kx < K; kx++) begin
                  a = (ib + (oy + ky) * w + ox + kx) % 4096;
                  exp_rd.push_back(a);
                  s += longint'($signed(mem[a])) * longint'($signed(mem[(kb + ky * K + kx) % 4096]));
               end
            s = s >>> sh;
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
`ifdef CNN_RELU_EN
            if (s < 0) s = 0;
`endif
            exp_wa.push_back((ob + oy * (w - K + 1) + ox) % 4096);
            exp_wd.push_back(int'(s) & 'hFFFF);
         end
   endtask

   task automatic fill(input int base, input int n, input logic [15:0] v);
      for (int i = 0; i < n; i++) mem[(base + i) % 4096] = v;
   endtask

   // compare process: every transfer against the reference stream, plus handshake stability
   always @(negedge clk) begin
      if (!rst_n) begin
         p_rd = 1'b0;
         p_wr = 1'b0;
      end else begin
         chk("rd_wr_exclusive", rd & wr, 0);
         if (p_rd && !p_rdy) begin
            chk("rd_held", rd, 1);
            chk("rd_addr_stable", addr, p_addr);
         end
         if (p_wr && !p_rdy) begin
            chk("wr_held", wr, 1);
            chk("wr_addr_stable", addr, p_addr);
            chk("wdata_stable", wdata, p_wdata);
         end
         if (rd && ready) begin
            if (exp_rd.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_read: got addr 0x%0h, want no read", addr);
            end else chk("rd_addr", addr, exp_rd.pop_front());
         end
         if (wr && ready) begin
            if (exp_wa.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_write: got addr 0x%0h, want no write", addr);
            end else begin
               chk("wr_addr", addr, exp_wa.pop_front());
               chk("wr_data", wdata, exp_wd.pop_front());
            end
            mem[addr] = wdata;
         end
         p_rd    = rd;
         p_wr    = wr;
         p_rdy   = ready;
         p_addr  = addr;
         p_wdata = wdata;
      end
   end

   // ready driver: always-ready, or random 0-5 cycle stalls between completions
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!stall_en) ready = 1'b1;
         else if (cnt > 0) begin
            ready = 1'b0;
            cnt--;
         end else begin
            ready = 1'b1;
            cnt = $urandom_range(0, 5);
         end
      end
   end

   task automatic run_job(input int ib, input int kb, input int ob, input int w, input int h, input int sh,
                          input bit timed, input bit poke, output int n_done);
      int want;
      bit bad;
      bad  = (w < K) || (h < K);
      want = bad ? 2 : K * K + (w - K + 1) * (h - K + 1) * (K * K + 1) + 1;
      build_expect(ib, kb, ob, w, h, sh);
      @(negedge clk);
      img_base = ib[11:0];
      ker_base = kb[11:0];
      out_base = ob[11:0];
      img_w    = w[7:0];
      img_h    = h[7:0];
      shift    = sh[4:0];
      start    = 1'b1;
      n_done   = 0;
      for (int n = 1; n <= 4000; n++) begin
         @(negedge clk);
         if (n == 1) start = 1'b0;
         if (poke && n == 5) begin
            start    = 1'b1;
            out_base = 12'h300;
            img_w    = 8'd5;
            img_h    = 8'd5;
            img_base = 12'h000;
         end
         if (poke && n == 6) start = 1'b0;
         chk("busy_during_job", busy, 1);
         if (done) begin
            n_done = n;
            break;
         end
      end
      if (n_done == 0) begin
         tests++;
         fails++;
         $display("FAIL done_timeout: got no done in 4000 cycles, want done");
      end else if (timed) chk("done_cycle", n_done, want);
      chk("err_at_done", err, bad);
      chk("reads_outstanding", exp_rd.size(), 0);
      chk("writes_outstanding", exp_wa.size(), 0);
      @(negedge clk);
      chk("busy_after_done", busy, 0);
      chk("done_one_cycle", done, 0);
   endtask

   initial begin
      int kv [9];
      kv = '{2, -1, 3, 0, 5, -4, 1, 1, -2};
      for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
      fill(12'h200, 256, 16'hDEAD);
      fill(12'h500, 16, 16'hDEAD);
      fill(12'h700, 16, 16'hDEAD);
      // reset state
      repeat (2) @(negedge clk);
      chk("rst_rd", rd, 0);
      chk("rst_wr", wr, 0);
      chk("rst_addr", addr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      rst_n = 1'b1;
      // 1: all-ones 4x4 image and kernel
      fill(12'h100, 16, 16'h0001);
      fill(12'h080, 9, 16'h0001);
      run_job(12'h100, 12'h080, 12'h200, 4, 4, 0, 1'b1, 1'b0, dn);
      chk("t1_done_at_50", dn, 50);
      for (int i = 0; i < 4; i++) chk("t1_out_is_9", mem[12'h200 + i], 16'h0009);
      // 2: saturation both ways, arithmetic shift of a negative sum, and a mixed-value image
      fill(12'h400, 9, 16'h7FFF);
      fill(12'h480, 9, 16'h7FFF);
      run_job(12'h400, 12'h480, 12'h500, 3, 3, 0, 1'b1, 1'b0, dn);
      chk("t2_pos_sat", mem[12'h500], 16'h7FFF);
      fill(12'h410, 9, 16'h8000);
      run_job(12'h410, 12'h480, 12'h501, 3, 3, 0, 1'b1, 1'b0, dn);
      fill(12'h420, 9, 16'hFFFD);
      run_job(12'h420, 12'h080, 12'h502, 3, 3, 2, 1'b1, 1'b0, dn);
`ifdef CNN_RELU_EN
      chk("t2_neg_sat_relu", mem[12'h501], 16'h0000);
      chk("t2_shift_neg_relu", mem[12'h502], 16'h0000);
`else
      chk("t2_neg_sat", mem[12'h501], 16'h8000);
      chk("t2_shift_neg", mem[12'h502], 16'hFFF9);
`endif
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 5; x++) mem[12'h600 + y * 5 + x] = 16'(x * 3 - y * 7 + 2);
      for (int i = 0; i < 9; i++) mem[12'h6A0 + i] = 16'(kv[i]);
      run_job(12'h600, 12'h6A0, 12'h700, 5, 4, 1, 1'b1, 1'b0, dn);
      // 3: illegal dimensions, then a legal job clears err
      run_job(12'h100, 12'h080, 12'h2F0, 2, 4, 0, 1'b1, 1'b0, dn);
      chk("t3_done_at_2", dn, 2);
      chk("t3_err_sticky", err, 1);
      run_job(12'h100, 12'h080, 12'h2F0, 4, 1, 0, 1'b1, 1'b0, dn);
      run_job(12'h100, 12'h080, 12'h208, 4, 4, 0, 1'b1, 1'b0, dn);
      chk("t3_err_cleared", err, 0);
      // 4: random ready stalls, same results as test 1
      stall_en = 1'b1;
      run_job(12'h100, 12'h080, 12'h210, 4, 4, 0, 1'b0, 1'b0, dn);
      stall_en = 1'b0;
      for (int i = 0; i < 4; i++) chk("t4_out_is_9", mem[12'h210 + i], 16'h0009);
      // 5: reset asserted during FETCH aborts, then a fresh job runs normally
      build_expect(12'h100, 12'h080, 12'h240, 4, 4, 0);
      @(negedge clk);
      img_base = 12'h100;
      ker_base = 12'h080;
      out_base = 12'h240;
      img_w    = 8'd4;
      img_h    = 8'd4;
      shift    = 5'd0;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (11) @(negedge clk);
      chk("t5_reading_in_fetch", rd, 1);
      rst_n = 1'b0;
      #1;
      chk("t5_abort_rd", rd, 0);
      chk("t5_abort_wr", wr, 0);
      chk("t5_abort_busy", busy, 0);
      chk("t5_abort_addr", addr, 0);
      exp_rd.delete();
      exp_wa.delete();
      exp_wd.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("t5_no_write_after_abort", mem[12'h240], 16'hDEAD);
      run_job(12'h100, 12'h080, 12'h220, 4, 4, 0, 1'b1, 1'b0, dn);
      for (int i = 0; i < 4; i++) chk("t5_out_is_9", mem[12'h220 + i], 16'h0009);
      // 6: image wraps past the top of memory; a start pulse mid-job is ignored
      mem[12'h300] = 16'hDEAD;
      for (int i = 0; i < 9; i++) mem[(12'hFFE + i) % 4096] = 16'(i + 1);
      run_job(12'hFFE, 12'h080, 12'h230, 3, 3, 0, 1'b1, 1'b1, dn);
      chk("t6_wrap_sum_45", mem[12'h230], 16'h002D);
      chk("t6_ignored_start_no_write", mem[12'h300], 16'hDEAD);
      chk("t6_done_at_20", dn, 20);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test by 500000, want finish");
      $fatal(1);
   end
endmodule
